// File: rtl/md5_arbiter_pkg.sv
// Shared types and helpers for the md5 core arbiter: one-hot FSM encoding
// and the modulo-wrap pointer increment.
package md5_arbiter_pkg;

  localparam int DIGEST_W = 128;

  localparam int ARB_IDLE  = 0;
  localparam int ARB_ISSUE = 1;
  localparam int ARB_WAIT  = 2;
  localparam int ARB_DRAIN = 3;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'(1 << ARB_IDLE),
    ST_ISSUE = 4'(1 << ARB_ISSUE),
    ST_WAIT  = 4'(1 << ARB_WAIT),
    ST_DRAIN = 4'(1 << ARB_DRAIN)
  } arb_state_t;

  function automatic int wrap_inc(input int v, input int n);
    return (v >= n - 1) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/md5_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping, found with a double-width masked priority encode.
module md5_arbiter_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            any,
  output logic [IDW-1:0]  idx
);

  logic [2*NREQ-1:0] dbl;
  logic [2*NREQ-1:0] mask;
  logic [2*NREQ-1:0] masked;
  int                first;

  always_comb begin
    dbl    = {req, req};
    // Lower copy below ptr is masked off; the upper copy supplies the wrap.
    mask   = ~(((2*NREQ)'(1) << ptr) - (2*NREQ)'(1));
    masked = dbl & mask;
    any    = |req;
    first  = 0;
    for (int i = 2*NREQ - 1; i >= 0; i--) begin
      if (masked[i]) first = i;
    end
    if (first >= NREQ) idx = IDW'(first - NREQ);
    else               idx = IDW'(first);
  end

endmodule

// File: rtl/md5_arbiter.sv
// Round-robin arbiter sharing one md5 core among NREQ requesters, with
// digest routing back to the issuing requester and a WAIT watchdog.
//
// Handshakes: a requester holds req_valid/req_data until it sees its one-cycle
// req_ready pulse; the core accepts a job in any cycle where core_in_valid and
// core_ready are both high; core_out_valid is a single-cycle strobe.
module md5_arbiter
  import md5_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 128,
  localparam int IDW    = (NREQ > 2) ? $clog2(NREQ) : 1,
  localparam int TW     = $clog2(TIMEOUT + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [DIGEST_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          resp_valid,
  output logic [DIGEST_W-1:0]      resp_data,
  output logic                     err_valid,
  output logic [IDW-1:0]           err_id,
  output logic [DIGEST_W-1:0]      core_in,
  output logic                     core_in_valid,
  input  logic                     core_ready,
  input  logic [DIGEST_W-1:0]      core_out,
  input  logic                     core_out_valid,
  output arb_state_t               state
);

  arb_state_t          state_next;
  logic [IDW-1:0]      ptr;
  logic [IDW-1:0]      owner;
  logic [IDW-1:0]      owner_inc;
  logic [TW-1:0]       timer;
  logic [DIGEST_W-1:0] data_q;
  logic [DIGEST_W-1:0] req_words [NREQ];
  logic                pick_any;
  logic [IDW-1:0]      pick_idx;
  logic                grant;
  logic                take_resp;
  logic                take_err;

  md5_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_words[i] = req_data[i*DIGEST_W +: DIGEST_W];
    end
  end

  assign owner_inc     = IDW'(wrap_inc(int'(owner), NREQ));
  assign core_in_valid = (state == ST_ISSUE);
  assign core_in       = (state == ST_ISSUE) ? data_q : '0;

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    take_resp  = 1'b0;
    take_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_any && core_ready) begin
          grant      = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (core_ready) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        // A digest arriving on the timeout cycle takes priority over the abort.
        if (core_out_valid) begin
          take_resp  = 1'b1;
          state_next = ST_DRAIN;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          take_err   = 1'b1;
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (core_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      owner      <= '0;
      timer      <= '0;
      data_q     <= '0;
      req_ready  <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      err_valid  <= 1'b0;
      err_id     <= '0;
    end else begin
      state      <= state_next;
      req_ready  <= '0;
      resp_valid <= '0;
      err_valid  <= 1'b0;
      if (grant) begin
        owner               <= pick_idx;
        data_q              <= req_words[pick_idx];
        req_ready[pick_idx] <= 1'b1;
      end
      if (state == ST_ISSUE) begin
        if (core_ready) timer <= '0;
      end else if (state == ST_WAIT) begin
        timer <= timer + 1'b1;
      end
      if (take_resp) begin
        resp_data         <= core_out;
        resp_valid[owner] <= 1'b1;
        ptr               <= owner_inc;
      end
      if (take_err) begin
        err_valid <= 1'b1;
        err_id    <= owner;
        ptr       <= owner_inc;
      end
    end
  end

endmodule

// File: tb/tb_md5_arbiter.sv
// Self-checking bench for md5_arbiter with a fixed-latency behavioural core
// stub that returns in ^ A5..A5; grants and responses go through scoreboards.
module tb_md5_arbiter;
  import md5_arbiter_pkg::*;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 128;
  localparam int IDW     = 2;
  localparam int W       = 133;
  localparam logic [127:0] XMASK = {16{8'hA5}};
  localparam logic [127:0] FIXED = 128'h0123456789ABCDEF0123456789ABCDEF;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req_valid = '0;
  logic [128*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    resp_valid;
  logic [127:0]       resp_data;
  logic               err_valid;
  logic [IDW-1:0]     err_id;
  logic [127:0]       core_in;
  logic               core_in_valid;
  logic               core_ready;
  logic [127:0]       core_out;
  logic               core_out_valid;
  arb_state_t         state;

  // clock / reset block
  always #5 clk = ~clk;

  md5_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .err_valid      (err_valid),
    .err_id         (err_id),
    .core_in        (core_in),
    .core_in_valid  (core_in_valid),
    .core_ready     (core_ready),
    .core_out       (core_out),
    .core_out_valid (core_out_valid),
    .state          (state)
  );

  // behavioural core stub
  int           stub_lat  = 66;
  bit           stub_hang = 1'b0;
  bit           stray     = 1'b0;
  logic [127:0] stray_data = '0;
  logic         busy;
  int           cnt;
  logic         stub_ov;
  logic [127:0] stub_out;
  logic [127:0] stub_hold;

  assign core_ready     = !busy;
  assign core_out_valid = stub_ov | stray;
  assign core_out       = stray ? stray_data : stub_out;

  always @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      cnt       <= 0;
      stub_ov   <= 1'b0;
      stub_out  <= '0;
      stub_hold <= '0;
    end else begin
      stub_ov <= 1'b0;
      if (!busy) begin
        if (core_in_valid) begin
          busy      <= 1'b1;
          cnt       <= 1;
          stub_hold <= core_in ^ XMASK;
        end
      end else begin
        cnt <= cnt + 1;
        if (!stub_hang && cnt == stub_lat - 1) begin
          stub_ov  <= 1'b1;
          stub_out <= stub_hold;
          busy     <= 1'b0;
        end else if (stub_hang && cnt == 200) begin
          busy <= 1'b0;
        end
      end
    end
  end

  // scoreboard state
  logic [W-1:0] exp_q[$];
  logic [3:0]   g_q[$];
  int           vectors     = 0;
  int           miscompares = 0;
  int           pend[NREQ];
  int           kidx[NREQ];
  logic [31:0]  base = 32'h0;
  bit           use_fixed = 1'b0;

  function automatic logic [127:0] word(input int i, input int k);
    if (use_fixed) return FIXED;
    return {base, 32'(i), 32'(k), ~base};
  endfunction

  function automatic void push_resp(input int i, input int k);
    exp_q.push_back({1'b0, 4'(1 << i), word(i, k) ^ XMASK});
  endfunction

  function automatic void push_err(input int i);
    exp_q.push_back({1'b1, 4'(1 << i), 128'h0});
  endfunction

  function automatic void push_grant(input int i);
    g_q.push_back(4'(1 << i));
  endfunction

  // driver tasks
  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]          = (pend[i] > 0);
      req_data[i*128 +: 128] = (pend[i] > 0) ? word(i, kidx[i]) : 128'h0;
    end
  endtask

  task automatic tick();
    logic [W-1:0] obs;
    logic [W-1:0] exp;
    logic [3:0]   gexp;
    @(negedge clk);
    if (resp_valid != 0 || err_valid) begin
      obs = {err_valid, err_valid ? (4'b0001 << err_id) : resp_valid,
             err_valid ? 128'h0 : resp_data};
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output: got %h, expected none", obs);
      end else begin
        exp = exp_q.pop_front();
        if (obs !== exp) begin
          miscompares++;
          $display("FAIL response: got %h, expected %h", obs, exp);
        end
      end
    end
    if (req_ready != 0) begin
      vectors++;
      if (g_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_grant: got %b, expected none", req_ready);
      end else begin
        gexp = g_q.pop_front();
        if (req_ready !== gexp) begin
          miscompares++;
          $display("FAIL grant: got %b, expected %b", req_ready, gexp);
        end
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i] === 1'b1 && pend[i] > 0) begin
        pend[i]--;
        kidx[i]++;
      end
    end
    apply();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    pend = '{default: 0};
    apply();
    tick();
    rst = 1'b0;
  endtask

  task automatic run_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || g_q.size() != 0 || state != ST_IDLE) && n < budget) begin
      tick();
      n++;
    end
    vectors++;
    if (exp_q.size() != 0 || g_q.size() != 0 || state != ST_IDLE) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d resp / %0d grants pending, state %b, expected 0/0 idle",
               exp_q.size(), g_q.size(), state);
      exp_q.delete();
      g_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pend = '{default: 0};
    apply();
    tick();
    tick();
    vectors += 8;
    if (req_ready !== '0)     begin miscompares++; $display("FAIL rst_req_ready: got %b, expected 0", req_ready); end
    if (resp_valid !== '0)    begin miscompares++; $display("FAIL rst_resp_valid: got %b, expected 0", resp_valid); end
    if (resp_data !== '0)     begin miscompares++; $display("FAIL rst_resp_data: got %h, expected 0", resp_data); end
    if (err_valid !== 1'b0)   begin miscompares++; $display("FAIL rst_err_valid: got %b, expected 0", err_valid); end
    if (err_id !== '0)        begin miscompares++; $display("FAIL rst_err_id: got %0d, expected 0", err_id); end
    if (core_in !== '0)       begin miscompares++; $display("FAIL rst_core_in: got %h, expected 0", core_in); end
    if (core_in_valid !== 1'b0) begin miscompares++; $display("FAIL rst_core_in_valid: got %b, expected 0", core_in_valid); end
    if (state !== ST_IDLE)    begin miscompares++; $display("FAIL rst_state: got %b, expected %b", state, ST_IDLE); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int n;
    reset_dut();
    kidx = '{default: 0};
    use_fixed = 1'b1;
    push_grant(2);
    push_resp(2, 0);
    pend[2] = 1;
    apply();
    tick();
    vectors += 3;
    if (req_ready !== 4'b0100)  begin miscompares++; $display("FAIL single_ready: got %b, expected 0100", req_ready); end
    if (core_in_valid !== 1'b1) begin miscompares++; $display("FAIL single_in_valid: got %b, expected 1", core_in_valid); end
    if (core_in !== FIXED)      begin miscompares++; $display("FAIL single_core_in: got %h, expected %h", core_in, FIXED); end
    n = 1;
    while (resp_valid === '0 && n < 200) begin
      tick();
      n++;
    end
    vectors += 3;
    if (n != 68)                     begin miscompares++; $display("FAIL single_latency: got %0d, expected 68", n); end
    if (resp_valid !== 4'b0100)      begin miscompares++; $display("FAIL single_resp_valid: got %b, expected 0100", resp_valid); end
    if (resp_data !== (FIXED ^ XMASK)) begin miscompares++; $display("FAIL single_resp_data: got %h, expected %h", resp_data, FIXED ^ XMASK); end
    tick();
    vectors += 2;
    if (state !== ST_IDLE)     begin miscompares++; $display("FAIL single_idle: got %b, expected %b", state, ST_IDLE); end
    if (resp_data !== (FIXED ^ XMASK)) begin miscompares++; $display("FAIL single_hold: got %h, expected %h", resp_data, FIXED ^ XMASK); end
    use_fixed = 1'b0;
  endtask

  task automatic test_round_robin();
    reset_dut();
    kidx = '{default: 0};
    base = $urandom;
    push_grant(0); push_resp(0, 0);
    push_grant(1); push_resp(1, 0);
    push_grant(2); push_resp(2, 0);
    push_grant(3); push_resp(3, 0);
    push_grant(0); push_resp(0, 1);
    pend = '{2, 1, 1, 1};
    apply();
    run_drain(1000);
  endtask

  task automatic test_wrap();
    reset_dut();
    kidx = '{default: 0};
    base = $urandom;
    push_grant(2); push_resp(2, 0);
    pend[2] = 1;
    apply();
    run_drain(200);
    push_grant(0); push_resp(0, 0);
    push_grant(1); push_resp(1, 0);
    pend[0] = 1;
    pend[1] = 1;
    apply();
    run_drain(400);
  endtask

  task automatic test_watchdog();
    int n;
    stub_hang = 1'b1;
    push_grant(1);
    push_err(1);
    pend[1] = 1;
    apply();
    tick();
    n = 1;
    while (!err_valid && n < 300) begin
      tick();
      n++;
    end
    vectors += 3;
    if (n != 130)           begin miscompares++; $display("FAIL wdog_latency: got %0d, expected 130", n); end
    if (err_id !== 2'd1)    begin miscompares++; $display("FAIL wdog_err_id: got %0d, expected 1", err_id); end
    if (state !== ST_DRAIN) begin miscompares++; $display("FAIL wdog_drain: got %b, expected %b", state, ST_DRAIN); end
    n = 0;
    while (!core_ready && n < 300) begin
      tick();
      n++;
    end
    vectors++;
    if (state !== ST_DRAIN) begin miscompares++; $display("FAIL wdog_hold: got %b, expected %b", state, ST_DRAIN); end
    tick();
    vectors++;
    if (state !== ST_IDLE)  begin miscompares++; $display("FAIL wdog_idle: got %b, expected %b", state, ST_IDLE); end
    stub_hang = 1'b0;
  endtask

  task automatic test_boundary();
    int n;
    stub_lat = 128;
    push_grant(2);
    push_resp(2, kidx[2]);
    pend[2] = 1;
    apply();
    tick();
    n = 1;
    while (resp_valid === '0 && !err_valid && n < 300) begin
      tick();
      n++;
    end
    vectors += 2;
    if (n != 130)          begin miscompares++; $display("FAIL edge_latency: got %0d, expected 130", n); end
    if (err_valid !== 1'b0) begin miscompares++; $display("FAIL edge_no_err: got %b, expected 0", err_valid); end
    run_drain(50);
    // one cycle too late: abort wins, the later digest lands in DRAIN
    stub_lat = 129;
    push_grant(3);
    push_err(3);
    pend[3] = 1;
    apply();
    tick();
    n = 1;
    while (resp_valid === '0 && !err_valid && n < 300) begin
      tick();
      n++;
    end
    vectors++;
    if (n != 130) begin miscompares++; $display("FAIL late_latency: got %0d, expected 130", n); end
    run_drain(50);
    stub_lat = 66;
    stray      = 1'b1;
    stray_data = {$urandom, $urandom, $urandom, $urandom};
    tick();
    stray = 1'b0;
    tick();
    vectors += 2;
    if (resp_valid !== '0) begin miscompares++; $display("FAIL stray_resp: got %b, expected 0", resp_valid); end
    if (state !== ST_IDLE) begin miscompares++; $display("FAIL stray_state: got %b, expected %b", state, ST_IDLE); end
  endtask

  task automatic test_mid_reset();
    reset_dut();
    kidx = '{default: 0};
    base = $urandom;
    push_grant(1); push_resp(1, 0);
    pend[1] = 1;
    apply();
    run_drain(200);
    push_grant(2);
    pend[2] = 1;
    apply();
    tick();
    repeat (20) tick();
    vectors++;
    if (state !== ST_WAIT) begin miscompares++; $display("FAIL mid_wait: got %b, expected %b", state, ST_WAIT); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors += 6;
    if (state !== ST_IDLE)      begin miscompares++; $display("FAIL mid_state: got %b, expected %b", state, ST_IDLE); end
    if (req_ready !== '0)       begin miscompares++; $display("FAIL mid_req_ready: got %b, expected 0", req_ready); end
    if (resp_valid !== '0)      begin miscompares++; $display("FAIL mid_resp_valid: got %b, expected 0", resp_valid); end
    if (resp_data !== '0)       begin miscompares++; $display("FAIL mid_resp_data: got %h, expected 0", resp_data); end
    if (err_valid !== 1'b0)     begin miscompares++; $display("FAIL mid_err_valid: got %b, expected 0", err_valid); end
    if (core_in_valid !== 1'b0) begin miscompares++; $display("FAIL mid_in_valid: got %b, expected 0", core_in_valid); end
    push_grant(1); push_resp(1, 1);
    push_grant(3); push_resp(3, 0);
    pend[1] = 1;
    pend[3] = 1;
    apply();
    tick();
    vectors++;
    if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL mid_regrant: got %b, expected 0010", req_ready); end
    run_drain(400);
  endtask

  initial begin
    pend = '{default: 0};
    kidx = '{default: 0};
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_watchdog();
    test_boundary();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
